sb_rx_deser: RTL

SB_RX_DESER -- requirements
Module: sb_rx_deser

---
 rtl/sb_rx_deser_pkg.sv | 12 +
 rtl/sb_rx_deser.sv | 112 +++++++++++
 2 files changed

// File: rtl/sb_rx_deser_pkg.sv
// Shared sideband definitions: deserializer state encoding and packet width.
package sb_rx_deser_pkg;

    localparam int SB_PKT_W = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DRAIN = 2'b10
    } sb_deser_state_t;

endpackage

// File: rtl/sb_rx_deser.sv
// Sideband RX deserializer: LSB-first serial bits to a DATA_W word, visible the cycle after the last bit.
// No backpressure: o_deser_done is held until acked; a packet completing while one is pending is dropped (o_overrun).
module sb_rx_deser
    import sb_rx_deser_pkg::*;
#(
    parameter int DATA_W = SB_PKT_W
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_deser_en,
    input  logic              i_rx_data_sb,
    input  logic              i_rx_vld,
    input  logic              i_deser_done_sampled,
    output logic [DATA_W-1:0] o_deser_data,
    output logic              o_deser_done,
    output logic              o_frame_err,
    output logic              o_overrun
);

    localparam int              CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

    sb_deser_state_t   r_state;
    logic [CNT_W-1:0]  r_cnt;
    // Only the newest DATA_W-1 bits are stored; the final bit is taken straight off the wire.
    logic [DATA_W-2:0] r_shreg;
    logic              r_drain_err;
    logic              r_armed;

    logic [DATA_W-1:0] w_word;
    logic              w_complete;

    assign w_word     = {i_rx_data_sb, r_shreg};
    assign w_complete = (r_state == SHIFT) && i_deser_en && i_rx_vld && (r_cnt == LAST_CNT);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_shreg      <= '0;
            r_drain_err  <= 1'b0;
            r_armed      <= 1'b0;
            o_deser_data <= '0;
            o_deser_done <= 1'b0;
            o_frame_err  <= 1'b0;
            o_overrun    <= 1'b0;
        end else begin
            o_frame_err <= 1'b0;
            o_overrun   <= 1'b0;
            // A frame may only start after i_rx_vld has been seen low, so a frame
            // cut by reset or disable is never picked up halfway through.
            r_armed     <= !i_rx_vld || (r_armed && i_deser_en);

            if (w_complete) begin
                if (o_deser_done) begin
                    o_overrun <= 1'b1;
                end else begin
                    o_deser_data <= w_word;
                    o_deser_done <= 1'b1;
                end
            end else if (i_deser_done_sampled) begin
                o_deser_done <= 1'b0;
            end

            if (!i_deser_en) begin
                r_state     <= IDLE;
                r_cnt       <= '0;
                r_drain_err <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (i_rx_vld && r_armed) begin
                            r_shreg <= w_word[DATA_W-1:1];
                            r_cnt   <= CNT_W'(1);
                            r_state <= SHIFT;
                        end
                    end
                    SHIFT: begin
                        if (i_rx_vld) begin
                            r_shreg <= w_word[DATA_W-1:1];
                            if (r_cnt == LAST_CNT) begin
                                r_cnt       <= '0;
                                r_drain_err <= 1'b0;
                                r_state     <= DRAIN;
                            end else begin
                                r_cnt <= r_cnt + 1'b1;
                            end
                        end else begin
                            r_cnt       <= '0;
                            o_frame_err <= 1'b1;
                            r_state     <= IDLE;
                        end
                    end
                    DRAIN: begin
                        if (!i_rx_vld) begin
                            r_drain_err <= 1'b0;
                            r_state     <= IDLE;
                        end else if (!r_drain_err) begin
                            o_frame_err <= 1'b1;
                            r_drain_err <= 1'b1;
                        end
                    end
                    default: begin
                        r_cnt   <= '0;
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
